// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared types and constants for the boot ROM loader.
// Holds the loader FSM encoding and the stream word width in bytes.
// Optional feature macro: ROM_LOADER_CHECKSUM_EN adds the S_CSUM state.
package rom_loader_pkg;

    localparam int BYTES_PER_WORD = 4;

`ifdef ROM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;
`endif

endpackage

// File: rtl/rom_loader_if.sv
// rom_loader_if: byte-stream input and ROM write port of the boot loader.
// Ports: rx_valid/rx_data/rx_ready (byte stream), rom_we/rom_waddr/rom_wdata.
// master = loader side, slave = byte source / ROM side.
interface rom_loader_if #(
    parameter int ADDR_W = 12
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_waddr;
    logic [31:0]       rom_wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output rom_we,
        output rom_waddr,
        output rom_wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  rom_we,
        input  rom_waddr,
        input  rom_wdata
    );
endinterface

// File: rtl/rom_loader_pack.sv
// rom_loader_pack: little-endian byte-to-word packer.
// Ports: clk, rst (async active-low), data/accept (byte in), clear,
//        word (32-bit, valid with the 4th byte), word_valid.
module rom_loader_pack
    import rom_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data,
    input  logic        accept,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  cnt;
    logic [23:0] low;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            low <= '0;
        end else if (clear) begin
            cnt <= '0;
            low <= '0;
        end else if (accept) begin
            cnt <= cnt + 2'd1;
            // LSB arrives first, so earlier bytes shift down.
            low <= {data, low[23:8]};
        end
    end

    // The 4th byte is used directly so the word is ready on its edge.
    assign word       = {data, low};
    assign word_valid = accept && (cnt == LAST);

endmodule

// File: rtl/rom_loader.sv
// rom_loader: boot loader writing a length-prefixed byte stream into ROM.
// Ports: clk, rst (async active-low), bus (rom_loader_if.master),
//        cpu_rst, done, error, words_loaded. Macro: ROM_LOADER_CHECKSUM_EN.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    rom_loader_if.master      bus,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int          MAX_WORDS = 2 ** ADDR_W;
    localparam logic [32:0] MAX_N     = 33'(MAX_WORDS);

    state_t          state;
    state_t          state_nx;
    logic            take;
    logic            in_field;
    logic            pk_valid;
    logic [31:0]     pk_word;
    logic [ADDR_W:0] n_words;
    logic            last_word;
    logic            len_big;
    logic            len_zero;

    assign take      = bus.rx_valid && bus.rx_ready;
    assign in_field  = (state == S_LEN) || (state == S_DATA);
    assign last_word = (words_loaded + (ADDR_W+1)'(1)) == n_words;
    assign len_big   = {1'b0, pk_word} > MAX_N;
    assign len_zero  = pk_word == 32'd0;

    rom_loader_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .data       (bus.rx_data),
        .accept     (take && in_field),
        .clear      (!in_field),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    localparam state_t S_TAIL = S_CSUM;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= '0;
        end else if (take && in_field) begin
            csum <= csum ^ bus.rx_data;
        end
    end

    assign bus.rx_ready = in_field || (state == S_CSUM);
`else
    localparam state_t S_TAIL = S_DONE;

    assign bus.rx_ready = in_field;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LEN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_LEN: begin
                if (pk_valid) begin
                    if (len_big) begin
                        state_nx = S_ERR;
                    end else if (len_zero) begin
                        state_nx = S_TAIL;
                    end else begin
                        state_nx = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (pk_valid && last_word) begin
                    state_nx = S_TAIL;
                end
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (take) begin
                    state_nx = (bus.rx_data == csum) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_words       <= '0;
            words_loaded  <= '0;
            bus.rom_we    <= 1'b0;
            bus.rom_waddr <= '0;
            bus.rom_wdata <= '0;
        end else begin
            bus.rom_we <= 1'b0;
            if (state == S_LEN && pk_valid) begin
                n_words <= pk_word[ADDR_W:0];
            end
            if (state == S_DATA && pk_valid) begin
                bus.rom_we    <= 1'b1;
                bus.rom_waddr <= words_loaded[ADDR_W-1:0];
                bus.rom_wdata <= pk_word;
                words_loaded  <= words_loaded + (ADDR_W+1)'(1);
            end
        end
    end

    // The FSM reaches S_DONE with the final write still in flight;
    // release the core only once that write has retired.
    assign done    = (state == S_DONE) && !bus.rom_we;
    assign cpu_rst = done;
    assign error   = state == S_ERR;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed self-checking bench for rom_loader.
// Expected ROM writes are queued per stimulus and checked by a monitor.
module tb_rom_loader;

    localparam int AW   = 12;
    localparam int MAXW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_rst;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;
    int            checks = 0;
    int            errors = 0;
    logic [7:0]    xsum;
    logic [43:0]   exp_q[$];

    rom_loader_if #(.ADDR_W(AW)) bus ();

    rom_loader #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rom_we pulse must match the next queued write.
    always @(negedge clk) begin
        if (rst && bus.rom_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(exp_q.size()), 64'd1);
            end else begin
                chk("rom_write", 64'({bus.rom_waddr, bus.rom_wdata}),
                    64'(exp_q.pop_front()));
            end
        end
    end

    task automatic push_wr(input int a, input logic [31:0] d);
        exp_q.push_back({12'(a), d});
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, 64'(bus.rx_ready), 64'd1);
        chk({tag, "_rom_we"}, 64'(bus.rom_we), 64'd0);
        chk({tag, "_rom_waddr"}, 64'(bus.rom_waddr), 64'd0);
        chk({tag, "_rom_wdata"}, 64'(bus.rom_wdata), 64'd0);
        chk({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_words"}, 64'(words_loaded), 64'd0);
    endtask

    // Called #1 after a rising edge; returns #1 after the next edge.
    task automatic do_reset(input string tag);
        bus.rx_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_vals(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // gap idle cycles, then one byte; returns #1 after its accept edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        chk("rx_ready", 64'(bus.rx_ready), 64'd1);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        xsum ^= b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], gap);
        end
    endtask

    task automatic start_load(input logic [31:0] n, input int gap);
        xsum = 8'h00;
        send_word(n, gap);
    endtask

    // Called right after the last data byte of a non-empty load.
    task automatic finish_load(input int gap, input int nexp);
`ifdef ROM_LOADER_CHECKSUM_EN
        send_byte(xsum, gap);
`else
        chk("we_after_last", 64'(bus.rom_we), 64'd1);
        chk("done_early", 64'(done), 64'd0);
        @(posedge clk);
        #1;
`endif
        chk("done", 64'(done), 64'd1);
        chk("cpu_rst", 64'(cpu_rst), 64'd1);
        chk("error_clear", 64'(error), 64'd0);
        chk("ready_done", 64'(bus.rx_ready), 64'd0);
        chk("words_loaded", 64'(words_loaded), 64'(nexp));
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        xsum = 8'h00;
        #1;
        check_reset_vals("por");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Normal back-to-back load
        push_wr(0, 32'h0000_0093);
        push_wr(1, 32'h0010_0113);
        start_load(32'd2, 0);
        send_word(32'h0000_0093, 0);
        send_word(32'h0010_0113, 0);
        finish_load(0, 2);
        repeat (3) @(posedge clk);
        #1;
        chk("done_sticky", 64'(done), 64'd1);

        // Throttled stream
        do_reset("rst1");
        push_wr(0, 32'h0000_0093);
        push_wr(1, 32'h0010_0113);
        start_load(32'd2, 3);
        send_word(32'h0000_0093, 3);
        send_word(32'h0010_0113, 3);
        finish_load(3, 2);

        // Oversize length
        do_reset("rst2");
        start_load(32'd4097, 0);
        chk("ovr_error", 64'(error), 64'd1);
        chk("ovr_ready", 64'(bus.rx_ready), 64'd0);
        chk("ovr_cpu_rst", 64'(cpu_rst), 64'd0);
        chk("ovr_done", 64'(done), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("ovr_sticky", 64'(error), 64'd1);
        chk("ovr_words", 64'(words_loaded), 64'd0);

        // Empty load
        do_reset("rst3");
        start_load(32'd0, 0);
`ifdef ROM_LOADER_CHECKSUM_EN
        chk("empty_wait_csum", 64'(done), 64'd0);
        send_byte(xsum, 0);
`endif
        chk("empty_done", 64'(done), 64'd1);
        chk("empty_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("empty_words", 64'(words_loaded), 64'd0);

        // Reset after 6 bytes, then reload one word with 0xFF/0x00 bytes
        do_reset("rst4");
        start_load(32'd2, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        do_reset("mid");
        push_wr(0, 32'hFF00_FF00);
        start_load(32'd1, 0);
        send_word(32'hFF00_FF00, 0);
        finish_load(0, 1);

        // Full capacity: last address MAXW-1, no wrap
        do_reset("rst5");
        for (int i = 0; i < MAXW; i++) begin
            push_wr(i, 32'(i) * 32'h9E37_79B1);
        end
        start_load(32'(MAXW), 0);
        for (int i = 0; i < MAXW; i++) begin
            send_word(32'(i) * 32'h9E37_79B1, 0);
        end
        finish_load(0, MAXW);

`ifdef ROM_LOADER_CHECKSUM_EN
        // Checksum match: bytes 01 00 00 00 78 56 34 12 XOR to 0x09
        do_reset("rst6");
        push_wr(0, 32'h1234_5678);
        start_load(32'd1, 0);
        send_word(32'h1234_5678, 0);
        send_byte(8'h09, 0);
        chk("csum_done", 64'(done), 64'd1);
        chk("csum_cpu_rst", 64'(cpu_rst), 64'd1);

        // Checksum mismatch
        do_reset("rst7");
        push_wr(0, 32'h1234_5678);
        start_load(32'd1, 0);
        send_word(32'h1234_5678, 0);
        send_byte(8'h0A, 0);
        chk("csum_error", 64'(error), 64'd1);
        chk("csum_bad_cpu_rst", 64'(cpu_rst), 64'd0);
        chk("csum_bad_done", 64'(done), 64'd0);
`endif

        chk("sb_final", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
